// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master port among NUM_REQ val/rdy requesters.
// Optional response watchdog enabled by defining ARB_TIMEOUT_EN.
module spi_master_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int NBITS   = 32,
    parameter int TIMEOUT = 255,
    localparam int GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_val,
    output logic [NUM_REQ-1:0]       req_rdy,
    input  logic [NUM_REQ*NBITS-1:0] req_msg,
    output logic [NUM_REQ-1:0]       resp_val,
    input  logic [NUM_REQ-1:0]       resp_rdy,
    output logic [NBITS-1:0]         resp_msg,
    output logic                     spi_req_val,
    input  logic                     spi_req_rdy,
    output logic [NBITS-1:0]         spi_req_msg,
    input  logic                     spi_resp_val,
    output logic                     spi_resp_rdy,
    input  logic [NBITS-1:0]         spi_resp_msg,
    output logic [GW-1:0]            grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEND   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   buf_q, buf_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      last_q, last_d;
    logic               found_s;
    logic [GW-1:0]      win_s;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               terr_q, terr_d;
`endif

    // Round-robin search starting one past the last completed grant.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(last_q) + 1 + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found_s && req_val[idx]) begin
                found_s = 1'b1;
                win_s   = GW'(idx);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Accept handshake is combinational and only offered while idle.
    always_comb begin
        req_rdy = '0;
        if (state_q == ST_IDLE && found_s) begin
            req_rdy[win_s] = 1'b1;
        end else begin
            req_rdy = '0;
        end
    end

    // Next-state and datapath for the transaction FSM.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        terr_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    buf_d   = req_msg[int'(win_s)*NBITS +: NBITS];
                    grant_d = win_s;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (spi_req_rdy) begin
                    state_d = ST_WAIT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (spi_resp_val) begin
                    buf_d   = spi_resp_msg;
                    state_d = ST_RETURN;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    // The counter reaching TIMEOUT this cycle ends the wait.
                    if (cnt_q == CW'(TIMEOUT - 1)) begin
                        buf_d   = '1;
                        terr_d  = 1'b1;
                        state_d = ST_RETURN;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_RETURN: begin
                if (resp_rdy[grant_q]) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RETURN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            grant_q <= '0;
            last_q  <= GW'(NUM_REQ - 1);
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            terr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
`endif
        end
    end

    // Response valid is a decode of registered state and grant.
    always_comb begin
        resp_val = '0;
        if (state_q == ST_RETURN) begin
            resp_val[grant_q] = 1'b1;
        end else begin
            resp_val = '0;
        end
    end

    assign resp_msg     = buf_q;
    assign spi_req_msg  = buf_q;
    assign spi_req_val  = (state_q == ST_SEND);
    assign spi_resp_rdy = (state_q == ST_WAIT);
    assign busy         = (state_q != ST_IDLE);
    assign grant_id     = grant_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout_err  = terr_q;
`else
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter: vector table of transactions plus
// hand sequences for reset-abort and (with ARB_TIMEOUT_EN) the watchdog.
module tb_spi_master_arbiter;
    localparam int N  = 3;
    localparam int NB = 32;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif
    localparam logic [NB-1:0] M0 = 32'hA5A5_0001;
    localparam logic [NB-1:0] M1 = 32'h5A5A_0102;
    localparam logic [NB-1:0] M2 = 32'h1234_0203;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_val, req_rdy, resp_val, resp_rdy;
    logic [N*NB-1:0] req_msg;
    logic [NB-1:0]   resp_msg, spi_req_msg, spi_resp_msg;
    logic            spi_req_val, spi_req_rdy, spi_resp_val, spi_resp_rdy;
    logic [1:0]      grant_id;
    logic            busy, timeout_err;

    assign req_msg = {M2, M1, M0};

    spi_master_arbiter #(.NUM_REQ(N), .NBITS(NB), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
        .spi_req_val(spi_req_val), .spi_req_rdy(spi_req_rdy), .spi_req_msg(spi_req_msg),
        .spi_resp_val(spi_resp_val), .spi_resp_rdy(spi_resp_rdy), .spi_resp_msg(spi_resp_msg),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int last_acc = -1;
    int last_extra = 0;

    typedef struct { int g; logic [NB-1:0] m; } exp_t;
    exp_t sbq[$];

    typedef struct { logic [N-1:0] val; int g; int rs; int ps; } vec_t;
    vec_t vt[10];

    function automatic logic [NB-1:0] getm(input int i);
        case (i)
            0:       return M0;
            1:       return M1;
            default: return M2;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic pop_chk(input string nm);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=empty_queue required=entry", nm);
        end else begin
            e = sbq.pop_front();
            chk({nm, "_msg"}, resp_msg, e.m);
            chk({nm, "_val"}, resp_val, 64'(1) << e.g);
            chk({nm, "_gid"}, grant_id, e.g);
        end
    endtask

    // One full transaction: accept, rs SEND stalls, echo response, ps RETURN stalls.
    task automatic do_txn(input logic [N-1:0] vm, input int g, input int rs, input int ps);
        exp_t e;
        @(negedge clk);
        req_val = vm; resp_rdy = '0; spi_req_rdy = 1'b0; spi_resp_val = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("accept_rdy", req_rdy, 64'(1) << g);
        if (last_acc >= 0) chk("txn_period", cyc - last_acc, 4 + last_extra);
        last_acc = cyc; last_extra = rs + ps;
        e.g = g; e.m = getm(g) + 32'd1;
        sbq.push_back(e);
        for (int k = 0; k < rs; k++) begin
            @(negedge clk); #1;
            chk("send_hold_val", spi_req_val, 1);
            chk("send_hold_msg", spi_req_msg, getm(g));
            chk("busy_rdy_low", req_rdy, 0);
        end
        @(negedge clk);
        spi_req_rdy = 1'b1;
        #1;
        chk("send_val", spi_req_val, 1);
        chk("send_msg", spi_req_msg, getm(g));
        chk("grant_id", grant_id, g);
        @(negedge clk);
        spi_req_rdy = 1'b0; spi_resp_val = 1'b1; spi_resp_msg = spi_req_msg + 32'd1;
        #1;
        chk("wait_rdy", spi_resp_rdy, 1);
        chk("wait_req_low", spi_req_val, 0);
        chk("wait_resp_low", resp_val, 0);
        @(negedge clk);
        spi_resp_val = 1'b0; spi_resp_msg = '0;
        resp_rdy = ~(N'(1) << g);
        for (int k = 0; k < ps; k++) begin
            #1;
            chk("ret_hold_val", resp_val, 64'(1) << g);
            chk("ret_hold_msg", resp_msg, getm(g) + 32'd1);
            chk("ret_no_grant", req_rdy, 0);
            @(negedge clk);
        end
        resp_rdy = '1;
        #1;
        chk("ret_terr", timeout_err, 0);
        pop_chk("sb");
    endtask

`ifdef ARB_TIMEOUT_EN
    // Watchdog transaction; resp_at=0 means the SPI side never answers.
    task automatic to_txn(input int g, input int resp_at);
        exp_t e;
        int n;
        @(negedge clk);
        req_val = N'(1) << g; resp_rdy = '0;
        #1;
        chk("to_accept", req_rdy, 64'(1) << g);
        e.g = g; e.m = (resp_at == 0) ? 32'hFFFF_FFFF : getm(g) + 32'd1;
        sbq.push_back(e);
        @(negedge clk);
        req_val = '0; spi_req_rdy = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            spi_req_rdy = 1'b0;
            n++;
            spi_resp_val = (n == resp_at);
            spi_resp_msg = getm(g) + 32'd1;
            #1;
        end while (spi_resp_rdy && n < 40);
        spi_resp_val = 1'b0;
        chk("to_wait_cycles", n - 1, (resp_at == 0) ? TO : resp_at);
        chk("to_terr_first", timeout_err, (resp_at == 0) ? 1 : 0);
        chk("to_ret_msg", resp_msg, e.m);
        @(negedge clk); #1;
        chk("to_terr_second", timeout_err, 0);
        resp_rdy = '1;
        #1;
        pop_chk("to_sb");
        last_acc = -1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{3'b001, 0, 0, 0};
        vt[1] = '{3'b111, 1, 0, 0};
        vt[2] = '{3'b111, 2, 0, 0};
        vt[3] = '{3'b111, 0, 0, 0};
        vt[4] = '{3'b111, 1, 0, 10};
        vt[5] = '{3'b111, 2, 5, 0};
        vt[6] = '{3'b101, 0, 0, 0};
        vt[7] = '{3'b100, 2, 0, 0};
        vt[8] = '{3'b011, 0, 0, 0};
        vt[9] = '{3'b011, 1, 0, 0};

        reset = 1'b1; req_val = '0; resp_rdy = '0;
        spi_req_rdy = 1'b0; spi_resp_val = 1'b0; spi_resp_msg = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("rst_req_rdy", req_rdy, 0);
            chk("rst_busy", busy, 0);
            chk("rst_grant", grant_id, 0);
            chk("rst_resp_val", resp_val, 0);
            chk("rst_resp_msg", resp_msg, 0);
            chk("rst_spi_val", spi_req_val, 0);
            chk("rst_spi_rdy", spi_resp_rdy, 0);
            chk("rst_terr", timeout_err, 0);
        end

        for (int i = 0; i < 10; i++) begin
            do_txn(vt[i].val, vt[i].g, vt[i].rs, vt[i].ps);
        end

`ifdef ARB_TIMEOUT_EN
        to_txn(2, 0);
        to_txn(0, 16);
`endif

        // Reset in the middle of WAIT, then requester 0 must win first.
        @(negedge clk);
        req_val = 3'b100; resp_rdy = '0;
        #1;
        chk("abort_accept", req_rdy, 3'b100);
        @(negedge clk);
        req_val = '0; spi_req_rdy = 1'b1;
        @(negedge clk);
        spi_req_rdy = 1'b0;
        #1;
        chk("abort_in_wait", spi_resp_rdy, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_spi_rdy", spi_resp_rdy, 0);
        chk("abort_grant", grant_id, 0);
        chk("abort_resp_val", resp_val, 0);
        chk("abort_resp_msg", resp_msg, 0);
        @(negedge clk);
        reset = 1'b0;
        sbq.delete();
        last_acc = -1;
        do_txn(3'b111, 0, 0, 0);
        do_txn(3'b111, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin arbiter that shares the single SPI master port of the FFT/SPI interconnect among several minion-side requesters. Each requester presents a packet on a val/rdy interface. The arbiter grants one requester, forwards its packet to the SPI master adapter, waits for the returned packet and routes it back to the same requester. The master is locked for the full transaction. The block sits between the minion adapters and the SPI master inside the interconnect, clocked from the Wishbone clock domain.

## Interface
Parameters:
- NUM_REQ, 3: number of requesters (2..8).
- NBITS, 32: packet width.
- TIMEOUT, 255: response watchdog limit in cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  block clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- req_val  in  NUM_REQ  per-requester request valid.
- req_rdy  out  NUM_REQ  per-requester request ready.
- req_msg  in  NUM_REQ*NBITS  request packets; requester i occupies bits [i*NBITS +: NBITS].
- resp_val  out  NUM_REQ  per-requester response valid; at most one bit high.
- resp_rdy  in  NUM_REQ  per-requester response ready.
- resp_msg  out  NBITS  shared response bus, qualified by resp_val.
- spi_req_val / spi_req_rdy / spi_req_msg  out / in / out  1/1/NBITS  request to the SPI master adapter.
- spi_resp_val / spi_resp_rdy / spi_resp_msg  in / out / in  1/1/NBITS  response from the SPI master adapter.
- grant_id  out  max(1,clog2(NUM_REQ))  index of the current or last granted requester.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.

## Operation
- The FSM has four states: IDLE, SEND, WAIT, RETURN.
- A single NBITS buffer holds the request, then the response.
- A last_grant pointer tracks round-robin order.
- **IDLE:**
  - Search req_val starting at index (last_grant+1) mod NUM_REQ, wrapping around.
  - The first set bit wins. In the same cycle, drive req_rdy[winner]=1 (combinational, only in IDLE), latch req_msg[winner] into the buffer and the winner index into grant_id, then go to SEND.
  - If no request is valid, stay in IDLE with all req_rdy low.
- **SEND:**
  - Drive spi_req_val=1 and spi_req_msg=buffer.
  - When spi_req_rdy=1, go to WAIT.
- **WAIT:**
  - Drive spi_resp_rdy=1.
  - When spi_resp_val=1, load the buffer with spi_resp_msg and go to RETURN.
- **RETURN:**
  - Drive resp_val[grant_id]=1 and resp_msg=buffer.
  - When resp_rdy[grant_id]=1, set last_grant=grant_id and go to IDLE.
  - resp_rdy on non-granted indices is ignored.
- Requests arriving while busy stay pending. Requesters must hold req_val and req_msg stable until accepted.
- Fairness: a requester with req_val continuously high is granted within NUM_REQ transactions.
- Reset values (asynchronous):
  - State IDLE, buffer 0, grant_id 0, last_grant NUM_REQ-1 (requester 0 has first priority).
  - All req_rdy, resp_val, spi_req_val and spi_resp_rdy 0; busy 0; timeout_err 0; resp_msg 0.
- Reset during any state aborts the transaction immediately. No response is delivered, and a partially sent SPI packet is abandoned.

## Timing
- Accept in IDLE at cycle t. spi_req_val is asserted at t+1.
- With spi_req_rdy high at t+1 and spi_resp_val high at t+2, resp_val is asserted at t+3.
- With resp_rdy high, the block is back in IDLE at t+4.
- Minimum 4 cycles per transaction; back-to-back grants every 4 cycles.
- All outputs except req_rdy are registered state decodes or registered values. req_rdy depends combinationally on req_val in IDLE.

## Configuration
- Macro: ARB_TIMEOUT_EN.
- **Defined:**
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle without spi_resp_val.
  - When the counter reaches TIMEOUT, the FSM goes to RETURN with the buffer set to all ones, and timeout_err pulses for exactly one cycle.
  - If spi_resp_val arrives in the same cycle the counter reaches TIMEOUT, the response wins and there is no error.
- **Undefined:** no counter exists, timeout_err is tied to 0, WAIT lasts indefinitely, and TIMEOUT is ignored.

## Test plan
- Reset, then idle inputs -> all outputs 0, busy=0, grant_id=0; a request 0 with msg 0xA5A5_0001 appears on spi_req_msg at t+1.
- All three req_val high, with the SPI side echoing request+1 -> grants go 0,1,2,0; requester i receives req_msg[i]+1 on resp_msg; each transaction takes 4 cycles.
- resp_rdy held low for 10 cycles in RETURN -> resp_val and resp_msg remain stable; no new grant until resp_rdy rises.
- spi_req_rdy held low for 5 cycles -> spi_req_val and spi_req_msg are held; resp_val is asserted 2 cycles after spi_req_rdy rises (with an immediate spi_resp_val).
- With ARB_TIMEOUT_EN and TIMEOUT=16, no spi_resp_val -> RETURN after 16 WAIT cycles, resp_msg=0xFFFF_FFFF, timeout_err is a single-cycle pulse. A response arriving on cycle 16 -> normal data, no error.
- reset asserted mid-WAIT -> outputs clear immediately. After release, requester 0 is granted first.
